// File: rtl/shift_pipe_sched.sv
// shift_pipe_sched: shares one pipelined barrel shifter between two requesters.
// Holds a stable control word, tags issued ops, and steers results into credit FIFOs.
module shift_pipe_sched #(
    parameter int WIDTH   = 32,
    parameter int SHW     = 5,
    parameter int LAT     = 6,
    parameter int FDEPTH  = 4,
    parameter int MAXWAIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_shift,
    input  logic             req0_rot,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_shift,
    input  logic             req1_rot,
    output logic [WIDTH-1:0] sh_a,
    output logic [SHW-1:0]   sh_shift,
    output logic             sh_rot,
    input  logic [WIDTH-1:0] sh_out,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             busy
);
    localparam int IW = $clog2(LAT + 1);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam int WW = $clog2(MAXWAIT);

    logic [1:0]       valid_w, rot_w, rdy_w;
    logic [WIDTH-1:0] data_w [2];
    logic [SHW-1:0]   shift_w [2];

    logic [SHW-1:0]   sh_shift_q;
    logic             sh_rot_q;
    logic [LAT-1:0]   tag_v_q, tag_id_q;
    logic [IW-1:0]    infl_q, infl_d;
    logic [IW-1:0]    infl_n_q [2];
    logic [IW-1:0]    infl_n_d [2];
    logic             rr_q;
    logic [WW-1:0]    w_q [2];
    logic [WW-1:0]    w_d [2];
    logic             drain_q, drain_d;
    logic [WIDTH-1:0] mem_q [2][FDEPTH];
    logic [PW-1:0]    wp_q [2];
    logic [PW-1:0]    rp_q [2];
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];

    logic [1:0] match, credit, elig, gnt, push, pop;
    logic       gid, retire, rid, drain_eff, drain_set;

    assign valid_w    = {req1_valid, req0_valid};
    assign rot_w      = {req1_rot, req0_rot};
    assign rdy_w      = {rsp1_ready, rsp0_ready};
    assign data_w[0]  = req0_data;
    assign data_w[1]  = req1_data;
    assign shift_w[0] = req0_shift;
    assign shift_w[1] = req1_shift;

    // Eligibility, round-robin grant, wait/drain tracking and next-state counts
    always_comb begin
        drain_eff = drain_q && (infl_q != '0);
        drain_set = 1'b0;
        for (int n = 0; n < 2; n++) begin
            match[n]  = (shift_w[n] == sh_shift_q) && (rot_w[n] == sh_rot_q);
            credit[n] = (32'(cnt_q[n]) + 32'(infl_n_q[n])) < FDEPTH;
            elig[n]   = valid_w[n] && credit[n] && !drain_eff && !rst
                        && ((infl_q == '0) || match[n]);
            w_d[n]    = '0;
            if (valid_w[n] && credit[n] && !match[n] && (infl_q != '0)) begin
                if (32'(w_q[n]) == MAXWAIT - 1) begin
                    w_d[n]    = w_q[n];
                    drain_set = 1'b1;
                end else begin
                    w_d[n] = w_q[n] + WW'(1);
                end
            end
        end
        if (elig == 2'b11) gnt = rr_q ? 2'b10 : 2'b01;
        else               gnt = elig;
        gid    = gnt[1];
        retire = tag_v_q[LAT-1];
        rid    = tag_id_q[LAT-1];
        push   = retire ? (rid ? 2'b10 : 2'b01) : 2'b00;
        infl_d = infl_q + IW'(gnt != 2'b00) - IW'(retire);
        for (int n = 0; n < 2; n++) begin
            pop[n]      = (cnt_q[n] != '0) && rdy_w[n];
            infl_n_d[n] = infl_n_q[n] + IW'(gnt[n]) - IW'(push[n]);
            cnt_d[n]    = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
        end
        drain_d = (infl_q == '0) ? 1'b0 : (drain_q || drain_set);
    end

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign sh_a       = (gnt != 2'b00) ? data_w[gid] : '0;
    assign sh_shift   = sh_shift_q;
    assign sh_rot     = sh_rot_q;
    assign rsp0_valid = cnt_q[0] != '0;
    assign rsp1_valid = cnt_q[1] != '0;
    assign rsp0_data  = mem_q[0][rp_q[0]];
    assign rsp1_data  = mem_q[1][rp_q[1]];
    assign busy       = (infl_q != '0) || rsp0_valid || rsp1_valid;

    // Control word, tag pipe, counters, arbitration and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_shift_q <= '0;
            sh_rot_q   <= 1'b0;
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            infl_q     <= '0;
            rr_q       <= 1'b0;
            drain_q    <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                infl_n_q[n] <= '0;
                w_q[n]      <= '0;
                wp_q[n]     <= '0;
                rp_q[n]     <= '0;
                cnt_q[n]    <= '0;
            end
        end else begin
            tag_v_q  <= {tag_v_q[LAT-2:0], gnt != 2'b00};
            tag_id_q <= {tag_id_q[LAT-2:0], gid};
            infl_q   <= infl_d;
            drain_q  <= drain_d;
            if (gnt != 2'b00) rr_q <= !gid;
            if ((gnt != 2'b00) && (infl_q == '0)) begin
                sh_shift_q <= shift_w[gid];
                sh_rot_q   <= rot_w[gid];
            end
            for (int n = 0; n < 2; n++) begin
                infl_n_q[n] <= infl_n_d[n];
                w_q[n]      <= w_d[n];
                cnt_q[n]    <= cnt_d[n];
                if (push[n]) wp_q[n] <= wp_q[n] + PW'(1);
                if (pop[n])  rp_q[n] <= rp_q[n] + PW'(1);
            end
        end
    end

    // Result FIFO storage; capture the retiring shifter output
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) mem_q[n][wp_q[n]] <= sh_out;
        end
    end
endmodule

// File: tb/tb_shift_pipe_sched.sv
// tb_shift_pipe_sched: directed and random checks of the shared shifter scheduler
// against a pipelined shifter stand-in and a per-requester result queue model.
module tb_shift_pipe_sched;
    localparam int LAT = 6;
    localparam int FD  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_rot;
    logic        req1_valid, req1_ready, req1_rot;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shift, req1_shift;
    logic [31:0] sh_a, sh_out;
    logic [4:0]  sh_shift;
    logic        sh_rot;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    shift_pipe_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shift(req0_shift), .req0_rot(req0_rot),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shift(req1_shift), .req1_rot(req1_rot),
        .sh_a(sh_a), .sh_shift(sh_shift), .sh_rot(sh_rot), .sh_out(sh_out),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    // Left shift / left rotate of d by s
    function automatic logic [31:0] ref_sh(logic [31:0] d, logic [4:0] s, logic r);
        logic [63:0] t;
        t = {d, d} << s;
        return r ? t[63:32] : (d << s);
    endfunction

    // Shifter stand-in: operand pipeline, final stage reads the live control word
    logic [31:0] raw_q [LAT-1];
    always @(posedge clk) begin
        raw_q[0] <= sh_a;
        for (int i = 1; i < LAT - 1; i++) raw_q[i] <= raw_q[i-1];
        sh_out <= ref_sh(raw_q[LAT-2], sh_shift, sh_rot);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Per-cycle scoreboard, then advance to the next falling edge
    task automatic adv();
        check("one_grant", 32'(req0_ready & req1_ready), 0);
        if (req0_ready) begin
            check("rdy0_valid", 32'(req0_valid), 1);
            check("sh_a0", sh_a, req0_data);
            q0.push_back(ref_sh(req0_data, req0_shift, req0_rot));
            check("credit0", 32'(q0.size() <= FD), 1);
        end
        if (req1_ready) begin
            check("rdy1_valid", 32'(req1_valid), 1);
            check("sh_a1", sh_a, req1_data);
            q1.push_back(ref_sh(req1_data, req1_shift, req1_rot));
            check("credit1", 32'(q1.size() <= FD), 1);
        end
        if (!req0_ready && !req1_ready) check("sh_a_idle", sh_a, 0);
        if (rsp0_valid && rsp0_ready) begin
            check("rsp0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                check("rsp0_data", rsp0_data, q0[0]);
                q0.delete(0);
            end
        end
        if (rsp1_valid && rsp1_ready) begin
            check("rsp1_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                check("rsp1_data", rsp1_data, q1[0]);
                q1.delete(0);
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rsp0v"}, 32'(rsp0_valid), 0);
        check({tag, "_rsp1v"}, 32'(rsp1_valid), 0);
        check({tag, "_rdy0"}, 32'(req0_ready), 0);
        check({tag, "_rdy1"}, 32'(req1_ready), 0);
        check({tag, "_sh_a"}, sh_a, 0);
        check({tag, "_shift"}, 32'(sh_shift), 0);
        check({tag, "_rot"}, 32'(sh_rot), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic idle_wait();
        bit done = 0;
        req0_valid = 0;
        req1_valid = 0;
        rsp0_ready = 1;
        rsp1_ready = 1;
        for (int c = 0; c < 80 && !done; c++) begin
            settle();
            if (!busy) done = 1;
            adv();
        end
        check("idle", 32'(busy), 0);
    endtask

    initial begin
        int prev, blocked, gap, got, gcnt;
        rst = 1;
        req0_valid = 0; req0_data = 0; req0_shift = 0; req0_rot = 0;
        req1_valid = 0; req1_data = 0; req1_shift = 0; req1_rot = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        repeat (3) @(negedge clk);
        settle();
        check_zero("reset");
        @(negedge clk);
        rst = 0;

        // Single rotate op on requester 0
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_data = 32'h8000_0001; req0_shift = 1; req0_rot = 1;
        settle();
        check("single_grant", 32'(req0_ready), 1);
        adv();
        req0_valid = 0;
        for (int c = 1; c <= 7; c++) begin
            settle();
            if (c == 1) begin
                check("single_shift", 32'(sh_shift), 1);
                check("single_rot", 32'(sh_rot), 1);
            end
            check("single_rspv", 32'(rsp0_valid), 32'(c == 7));
            if (c == 7) check("single_rsp_data", rsp0_data, 32'h0000_0003);
            adv();
        end
        idle_wait();

        // Matching stream from both requesters alternates one grant per cycle
        req0_valid = 1; req1_valid = 1;
        req0_shift = 4; req1_shift = 4; req0_rot = 0; req1_rot = 0;
        prev = -1;
        for (int c = 0; c < 24; c++) begin
            req0_data = $urandom; req1_data = $urandom;
            settle();
            check("stream_one", 32'(req0_ready ^ req1_ready), 1);
            if (prev >= 0) check("stream_alt", 32'(req1_ready), 32'(prev == 0));
            prev = int'(req1_ready);
            adv();
        end
        idle_wait();

        // Control conflict forces a drain before requester 1 gets in
        req0_valid = 1; req0_shift = 3; req0_rot = 0;
        repeat (2) begin
            req0_data = $urandom;
            tick();
        end
        req1_valid = 1; req1_shift = 7; req1_rot = 0;
        blocked = 0; gap = 0; got = 0;
        for (int c = 0; c < 80 && got == 0; c++) begin
            req0_data = $urandom; req1_data = $urandom;
            settle();
            if (req1_ready) got = 1;
            else begin
                blocked++;
                gap = req0_ready ? 0 : gap + 1;
            end
            adv();
        end
        check("conflict_granted", 32'(got), 1);
        check("conflict_wait", 32'(blocked >= 8), 1);
        check("drain_gap", 32'(gap >= LAT), 1);
        req0_valid = 0; req1_valid = 0;
        settle();
        check("ctl_switch", 32'(sh_shift), 7);
        adv();
        idle_wait();

        // Backpressure: FIFO credits cap outstanding ops at the FIFO depth
        rsp0_ready = 0; req0_valid = 1; req0_shift = 2; req0_rot = 0;
        gcnt = 0;
        for (int c = 0; c < 20; c++) begin
            req0_data = $urandom;
            settle();
            gcnt += int'(req0_ready);
            adv();
        end
        check("bp_grants", 32'(gcnt), FD);
        settle();
        check("bp_full_valid", 32'(rsp0_valid), 1);
        rsp0_ready = 1;
        adv();
        rsp0_ready = 0;
        gcnt = 0;
        for (int c = 0; c < 12; c++) begin
            req0_data = $urandom;
            settle();
            gcnt += int'(req0_ready);
            adv();
        end
        check("bp_after_pop", 32'(gcnt), 1);
        idle_wait();

        // Random traffic with mixed controls and consumer stalls
        for (int c = 0; c < 600; c++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_data = $urandom; req1_data = $urandom;
            req0_shift = $urandom_range(0, 1) ? 5'd3 : 5'd9;
            req1_shift = $urandom_range(0, 1) ? 5'd3 : 5'd9;
            req0_rot = ($urandom_range(0, 3) == 0);
            req1_rot = ($urandom_range(0, 3) == 0);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_wait();
        check("rand_q0_empty", 32'(q0.size()), 0);
        check("rand_q1_empty", 32'(q1.size()), 0);

        // Reset with three ops in flight discards them
        req0_valid = 1; req0_shift = 6; req0_rot = 1;
        repeat (3) begin
            req0_data = $urandom;
            tick();
        end
        req0_valid = 0;
        rst = 1;
        q0.delete();
        q1.delete();
        tick();
        rst = 0;
        req0_shift = 0; req0_rot = 0;
        settle();
        check_zero("midrst");
        adv();
        for (int c = 0; c < 12; c++) begin
            settle();
            check("late_rsp0", 32'(rsp0_valid), 0);
            check("late_rsp1", 32'(rsp1_valid), 0);
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shift_pipe_sched.md
# shift_pipe_sched

Scheduler that shares the 6-stage pipelined 32-bit barrel shifter between two requesters. The shifter reads its shift amount and rotate flag live at every stage, so this block holds a single registered control word stable while operations are in flight. It admits only operations whose control matches that word, and switches the word only when the pipe is empty. It tags each issued operation with its requester ID through a latency-matched tag pipeline and steers results into per-requester credit-managed result FIFOs.

## Interface
Parameters:
- WIDTH, 32, data width; must equal the shifter width
- SHW, 5, shift-amount width
- LAT, 6, shifter latency in clock edges from sh_a to sh_out
- FDEPTH, 4, per-requester result FIFO depth (power of two, ≥2)
- MAXWAIT, 8, cycles a blocked requester waits before forcing a drain

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  request valid, N∈{0,1}
- reqN_ready  out  1  request accepted this cycle
- reqN_data  in  WIDTH  operand
- reqN_shift  in  SHW  shift amount
- reqN_rot  in  1  1 = rotate, 0 = logical shift
- sh_a  out  WIDTH  operand to the shifter; reqN_data of the granted requester, else 0
- sh_shift  out  SHW  registered control word to the shifter
- sh_rot  out  1  registered control word to the shifter
- sh_out  in  WIDTH  shifter result
- rspN_valid  out  1  result available
- rspN_ready  in  1  consumer accepts the result
- rspN_data  out  WIDTH  result (head of FIFO N)
- busy  out  1  any op in flight or any FIFO non-empty

## Operation
- State:
  - ctl register {sh_shift, sh_rot}
  - tag pipe of LAT entries {v, id}
  - inflight counter (0..LAT) and inflight_N per requester
  - RR pointer rr
  - wait counters wN
  - drain flag
  - two result FIFOs
- credit_N = FDEPTH − fifo_count_N − inflight_N. Issue for N requires credit_N>0.
- match_N = (reqN_shift==sh_shift && reqN_rot==sh_rot).
- eligible_N = reqN_valid && credit_N>0 && !drain && (inflight==0 || match_N).
- Grant:
  - If both requesters are eligible, grant rr.
  - If one is eligible, grant that one.
  - At most one grant per cycle.
  - reqN_ready = grant_N, a combinational function of the request inputs and registered state.
- On a grant:
  - Tag pipe stage 0 ← {1, N}; inflight and inflight_N increment.
  - rr ← other requester.
  - If inflight==0, ctl ← {reqN_shift, reqN_rot}.
  - ctl never changes while inflight>0.
- Tag pipe advances every cycle. The entry leaving stage LAT−1 with v=1:
  - pushes sh_out into FIFO[id];
  - decrements inflight and inflight_id in the same cycle.
  - A grant and a retire in the same cycle leave inflight unchanged.
- Anti-starvation:
  - wN increments when reqN_valid && credit_N>0 && !match_N && inflight>0, and clears otherwise.
  - When wN reaches MAXWAIT−1, drain←1.
  - drain blocks all grants until inflight==0. It clears that cycle, and the blocked requester is then eligible.
- FIFOs:
  - rspN_valid = FIFO N non-empty.
  - A pop occurs on rspN_valid && rspN_ready.
  - Push and pop in the same cycle on a full FIFO are legal.
  - Overflow is impossible by credit accounting.
  - Push into a non-empty FIFO never alters rspN_data.

## Timing
- Reset: all outputs 0 (rspN_valid=0, reqN_ready=0, sh_a=0, sh_shift=0, sh_rot=0, busy=0). Reset also clears:
  - the tag pipe, inflight counts, wait counters and drain;
  - FIFOs, which are emptied;
  - rr, which is set to 0.
- Reset mid-operation discards in-flight ops; the sh_out values that later arrive are ignored.
- Op granted in cycle t: sh_a valid in cycle t and sampled by the shifter at edge t+1. Its ctl is stable in cycles t+1..t+LAT−1.
- Result appears on sh_out in cycle t+LAT, is pushed at edge t+LAT+1, and rspN_valid is high in cycle t+LAT+1. Total latency is LAT+1 cycles.
- Throughput: 1 op/cycle for a matching stream. A control change costs up to LAT idle cycles (drain).
- Results of a requester return in issue order.

## Test plan
- Single op: req0 data=0x8000_0001, shift=1, rot=1 at cycle 0 -> sh_shift=1, sh_rot=1 from cycle 1; rsp0_valid in cycle 7 carrying sh_out from cycle 6.
- Matching stream: both requesters continuously valid, shift=4, rot=0 -> grants alternate 0,1,0,1 with one grant per cycle; tags route each result to the correct FIFO in order.
- Control conflict: req0 streaming shift=3, req1 valid with shift=7 -> req1 blocked and drain set after 8 cycles; grants stop until inflight=0; req1 is granted next and sh_shift becomes 7.
- Backpressure: rsp0_ready=0, FDEPTH=4 -> exactly 4 req0 grants, then req0_ready stays 0 until one pop, after which 1 more grant occurs.
- Simultaneous grant and retire at inflight=LAT, plus push and pop on a full FIFO -> counts are unchanged, no data loss, and no duplicate output.
- rst asserted with 3 ops in flight -> all outputs 0 the next cycle; the late sh_out values produce no rspN_valid.
